core8_mem_copy_master: RTL and testbench

- Avalon-MM master for the Core8 on-chip RAM s1/s2 slave port.
- The slave is single-port with 13-bit word addressing, 32-bit data, byteenables and no waitrequest. Read data is unregistered, so it is valid in the cycle after the read address.
- Per command, the block either copies a block of words from source to destination in the same RAM, or fills a block with a constant.
- Lets a core offload bulk memory moves and clears. Also reports a 32-bit running sum of the data it wrote.

---
 rtl/core8_mem_copy_master_pkg.sv | 21 ++
 rtl/core8_mem_copy_master_if.sv | 39 +++
 rtl/core8_mem_copy_master.sv | 171 +++++++++++++++++
 tb/tb_core8_mem_copy_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core8_mem_copy_master_pkg.sv
// ----------------------------------------------------------------------------
// core8_mem_pkg
// Shared definitions for the Core8 on-chip RAM and its copy/fill master:
// RAM geometry constants and the master's FSM state encoding.
// ----------------------------------------------------------------------------
package core8_mem_pkg;

  localparam int CORE8_RAM_ADDR_W     = 13;
  localparam int CORE8_RAM_DATA_W     = 32;
  localparam int CORE8_RAM_DEPTH      = 8192;
  localparam int CORE8_RAM_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } core8_state_e;

endpackage

// File: rtl/core8_mem_copy_master_if.sv
// ----------------------------------------------------------------------------
// core8_mem_copy_master_if
// Avalon-MM bundle between the copy/fill master and the Core8 RAM s1/s2 port.
//   avm_address    master -> slave  word address
//   avm_byteenable master -> slave  byte lane enables
//   avm_chipselect master -> slave  access strobe
//   avm_write      master -> slave  1 = write, 0 = read
//   avm_writedata  master -> slave  write data
//   avm_readdata   slave -> master  read data (valid the cycle after the read)
//   avm_clken      master -> slave  RAM clock enable
// ----------------------------------------------------------------------------
interface core8_mem_copy_master_if
  import core8_mem_pkg::*;
#(
  parameter int ADDR_W = CORE8_RAM_ADDR_W,
  parameter int DATA_W = CORE8_RAM_DATA_W
);

  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_clken;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write,
           avm_writedata, avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write,
           avm_writedata, avm_clken,
    output avm_readdata
  );

endinterface

// File: rtl/core8_mem_copy_master.sv
// ----------------------------------------------------------------------------
// core8_mem_copy_master
// Avalon-MM master that copies a block of words inside the Core8 RAM or fills
// a block with a constant, and reports the 32-bit running sum of written data.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cmd_start           one-cycle command pulse (accepted only when idle)
//   cmd_fill            1 = fill with cmd_pattern, 0 = copy cmd_src -> cmd_dst
//   cmd_src/cmd_dst     source / destination word addresses
//   cmd_len             word count, 0..8192
//   cmd_pattern         fill value
//   busy, done          command in flight / one-cycle completion pulse
//   checksum            mod-2^32 sum of words written by the last command
//   avm                 Avalon-MM master bundle to the RAM
// ----------------------------------------------------------------------------
module core8_mem_copy_master
  import core8_mem_pkg::*;
#(
  parameter int ADDR_W = CORE8_RAM_ADDR_W,
  parameter int DATA_W = CORE8_RAM_DATA_W,
  parameter int LEN_W  = 14
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_start,
  input  logic                           cmd_fill,
  input  logic [ADDR_W-1:0]              cmd_src,
  input  logic [ADDR_W-1:0]              cmd_dst,
  input  logic [LEN_W-1:0]               cmd_len,
  input  logic [DATA_W-1:0]              cmd_pattern,
  output logic                           busy,
  output logic                           done,
  output logic [DATA_W-1:0]              checksum,
  core8_mem_copy_master_if.master        avm
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_RD   = ST_RD;
  localparam logic [2:0] S_CAP  = ST_CAP;
  localparam logic [2:0] S_WR   = ST_WR;
  localparam logic [2:0] S_DONE = ST_DONE;

  logic [2:0]          r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_remaining;
  logic                r_fill;
  logic [DATA_W-1:0]   r_pattern;
  logic [DATA_W-1:0]   r_checksum;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W/8-1:0] r_byteenable;
  logic                r_chipselect;
  logic                r_write;
  logic [DATA_W-1:0]   r_writedata;
  logic                r_clken;

  // Bus outputs are registered: each transition loads the values the bus must
  // show during the state being entered, so RD/WR drive chipselect directly
  // from flops. In CAP the RAM's unregistered readdata is captured straight
  // into the writedata register used by the following WR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_remaining  <= '0;
      r_fill       <= 1'b0;
      r_pattern    <= '0;
      r_checksum   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_address    <= '0;
      r_byteenable <= '0;
      r_chipselect <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
      r_clken      <= 1'b0;
    end else begin
      r_clken <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_src       <= cmd_src;
            r_dst       <= cmd_dst;
            r_remaining <= cmd_len;
            r_fill      <= cmd_fill;
            r_pattern   <= cmd_pattern;
            r_checksum  <= '0;
            r_busy      <= 1'b1;
            if (cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (cmd_fill) begin
              r_state      <= S_WR;
              r_chipselect <= 1'b1;
              r_write      <= 1'b1;
              r_byteenable <= '1;
              r_address    <= cmd_dst;
              r_writedata  <= cmd_pattern;
            end else begin
              r_state      <= S_RD;
              r_chipselect <= 1'b1;
              r_write      <= 1'b0;
              r_byteenable <= '1;
              r_address    <= cmd_src;
            end
          end
        end
        S_RD: begin
          r_state      <= S_CAP;
          r_chipselect <= 1'b0;
          r_byteenable <= '0;
        end
        S_CAP: begin
          r_state      <= S_WR;
          r_chipselect <= 1'b1;
          r_write      <= 1'b1;
          r_byteenable <= '1;
          r_address    <= r_dst;
          r_writedata  <= avm.avm_readdata;
        end
        S_WR: begin
          // The word on the bus this cycle is the one being written.
          r_checksum  <= r_checksum + r_writedata;
          r_dst       <= r_dst + ADDR_W'(1);
          r_src       <= r_src + ADDR_W'(1);
          r_remaining <= r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_chipselect <= 1'b0;
            r_write      <= 1'b0;
            r_byteenable <= '0;
          end else if (r_fill) begin
            r_address <= r_dst + ADDR_W'(1);
          end else begin
            r_state   <= S_RD;
            r_write   <= 1'b0;
            r_address <= r_src + ADDR_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_chipselect <= 1'b0;
          r_write      <= 1'b0;
          r_byteenable <= '0;
        end
      endcase
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign checksum           = r_checksum;
  assign avm.avm_address    = r_address;
  assign avm.avm_byteenable = r_byteenable;
  assign avm.avm_chipselect = r_chipselect;
  assign avm.avm_write      = r_write;
  assign avm.avm_writedata  = r_writedata;
  assign avm.avm_clken      = r_clken;

endmodule

// File: tb/tb_core8_mem_copy_master.sv
// ----------------------------------------------------------------------------
// tb_core8_mem_copy_master
// Directed bench for the Core8 copy/fill master, with a behavioural model of
// the Core8 on-chip RAM (registered address, unregistered read data) as slave.
// ----------------------------------------------------------------------------
module tb_core8_mem_copy_master;
  import core8_mem_pkg::*;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmdStart = 1'b0;
  logic cmdFill = 1'b0;
  logic [ADDR_W-1:0] cmdSrc = '0;
  logic [ADDR_W-1:0] cmdDst = '0;
  logic [LEN_W-1:0] cmdLen = '0;
  logic [DATA_W-1:0] cmdPattern = '0;
  logic busy;
  logic done;
  logic [DATA_W-1:0] checksum;

  int checkCount = 0;
  int passCount = 0;
  int csSeen = 0;
  int doneSeen = 0;

  always #5 clk = ~clk;

  core8_mem_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avmIf ();

  core8_mem_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_start(cmdStart),
    .cmd_fill(cmdFill),
    .cmd_src(cmdSrc),
    .cmd_dst(cmdDst),
    .cmd_len(cmdLen),
    .cmd_pattern(cmdPattern),
    .busy(busy),
    .done(done),
    .checksum(checksum),
    .avm(avmIf)
  );

  // RAM model: address is registered, read data comes straight from the array.
  logic [DATA_W-1:0] ram [0:CORE8_RAM_DEPTH-1];
  logic [ADDR_W-1:0] ramAddrQ = '0;
  logic plEn = 1'b0;
  logic [ADDR_W-1:0] plAddr = '0;
  logic [DATA_W-1:0] plData = '0;

  always @(posedge clk) begin
    if (plEn) begin
      ram[plAddr] <= plData;
    end else if (avmIf.avm_chipselect && avmIf.avm_clken) begin
      ramAddrQ <= avmIf.avm_address;
      if (avmIf.avm_write) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (avmIf.avm_byteenable[b]) ram[avmIf.avm_address][8*b +: 8] <= avmIf.avm_writedata[8*b +: 8];
        end
      end
    end
  end

  assign avmIf.avm_readdata = ram[ramAddrQ];

  always @(negedge clk) begin
    if (avmIf.avm_chipselect === 1'b1) csSeen <= csSeen + 1;
    if (done === 1'b1) doneSeen <= doneSeen + 1;
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    plEn = 1'b1;
    plAddr = a;
    plData = d;
    @(posedge clk);
    #1 plEn = 1'b0;
  endtask

  task automatic startCmd(input logic fill, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                          input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] pat);
    @(negedge clk);
    cmdFill = fill;
    cmdSrc = src;
    cmdDst = dst;
    cmdLen = len;
    cmdPattern = pat;
    cmdStart = 1'b1;
    @(posedge clk);
    #1 cmdStart = 1'b0;
  endtask

  // Cycles from the accepting edge to the first done sample; -1 on timeout.
  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else passCount++;
    checkCount++; if (avmIf.avm_chipselect !== 1'b0) $display("[TB] FAIL reset_cs: got %b want 0", avmIf.avm_chipselect); else passCount++;
    checkCount++; if (avmIf.avm_clken !== 1'b0) $display("[TB] FAIL reset_clken: got %b want 0", avmIf.avm_clken); else passCount++;
    checkCount++; if (checksum !== 32'h0) $display("[TB] FAIL reset_checksum: got %h want 0", checksum); else passCount++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++; if (avmIf.avm_clken !== 1'b1) $display("[TB] FAIL clken_after_reset: got %b want 1", avmIf.avm_clken); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL busy_after_reset: got %b want 0", busy); else passCount++;
  endtask

  task automatic test_fill;
    int cyc;
    int csBase;
    logic [DATA_W-1:0] word;
    csBase = csSeen;
    startCmd(1'b1, 13'h0, 13'h0100, 14'd4, 32'hA5A5A5A5);
    waitDone(cyc);
    checkCount++; if (cyc !== 5) $display("[TB] FAIL fill_latency: got %0d want 5", cyc); else passCount++;
    checkCount++; if (checksum !== 32'h96969694) $display("[TB] FAIL fill_checksum: got %h want 96969694", checksum); else passCount++;
    for (int i = 0; i < 4; i++) begin
      word = ram[13'h0100 + i];
      checkCount++; if (word !== 32'hA5A5A5A5) $display("[TB] FAIL fill_word%0d: got %h want a5a5a5a5", i, word); else passCount++;
    end
    @(negedge clk);
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL fill_done_width: got %b want 0", done); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL fill_busy_end: got %b want 0", busy); else passCount++;
    checkCount++; if (csSeen - csBase !== 4) $display("[TB] FAIL fill_cs_cycles: got %0d want 4", csSeen - csBase); else passCount++;
  endtask

  task automatic test_copy;
    int cyc;
    int capBad;
    logic [DATA_W-1:0] word;
    for (int i = 0; i < 4; i++) preload(13'(i), 32'(i + 1));
    startCmd(1'b0, 13'h0, 13'h0200, 14'd4, 32'h0);
    cyc = -1;
    capBad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if ((k % 3 == 2) && avmIf.avm_chipselect !== 1'b0) capBad++;
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
    checkCount++; if (cyc !== 13) $display("[TB] FAIL copy_latency: got %0d want 13", cyc); else passCount++;
    checkCount++; if (capBad !== 0) $display("[TB] FAIL copy_cap_idle: got %0d busy CAP cycles want 0", capBad); else passCount++;
    checkCount++; if (checksum !== 32'd10) $display("[TB] FAIL copy_checksum: got %h want 0000000a", checksum); else passCount++;
    for (int i = 0; i < 4; i++) begin
      word = ram[13'h0200 + i];
      checkCount++; if (word !== 32'(i + 1)) $display("[TB] FAIL copy_word%0d: got %h want %h", i, word, 32'(i + 1)); else passCount++;
    end
  endtask

  task automatic test_wrap;
    int cyc;
    logic [DATA_W-1:0] exp [3];
    logic [DATA_W-1:0] word;
    exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33;
    preload(13'h1FFE, 32'h11);
    preload(13'h1FFF, 32'h22);
    preload(13'h0000, 32'h33);
    startCmd(1'b0, 13'h1FFE, 13'h0800, 14'd3, 32'h0);
    waitDone(cyc);
    checkCount++; if (cyc !== 10) $display("[TB] FAIL wrap_latency: got %0d want 10", cyc); else passCount++;
    for (int i = 0; i < 3; i++) begin
      word = ram[13'h0800 + i];
      checkCount++; if (word !== exp[i]) $display("[TB] FAIL wrap_word%0d: got %h want %h", i, word, exp[i]); else passCount++;
    end
    checkCount++; if (checksum !== 32'h66) $display("[TB] FAIL wrap_checksum: got %h want 00000066", checksum); else passCount++;
  endtask

  task automatic test_len0;
    int cyc;
    int csBase;
    csBase = csSeen;
    startCmd(1'b0, 13'h0005, 13'h0700, 14'd0, 32'h0);
    waitDone(cyc);
    checkCount++; if (cyc !== 1) $display("[TB] FAIL len0_latency: got %0d want 1", cyc); else passCount++;
    checkCount++; if (checksum !== 32'h0) $display("[TB] FAIL len0_checksum: got %h want 0", checksum); else passCount++;
    repeat (3) @(negedge clk);
    checkCount++; if (csSeen - csBase !== 0) $display("[TB] FAIL len0_no_cs: got %0d want 0", csSeen - csBase); else passCount++;
  endtask

  task automatic test_ignore_restart;
    int doneBase;
    logic [DATA_W-1:0] word;
    for (int i = 0; i < 4; i++) preload(13'h0600 + 13'(i), 32'(i + 5));
    preload(13'h0500, 32'hDEADBEEF);
    doneBase = doneSeen;
    startCmd(1'b0, 13'h0600, 13'h0400, 14'd4, 32'h0);
    startCmd(1'b1, 13'h0000, 13'h0500, 14'd1, 32'h12345678);
    repeat (30) @(negedge clk);
    checkCount++; if (doneSeen - doneBase !== 1) $display("[TB] FAIL ignore_done_count: got %0d want 1", doneSeen - doneBase); else passCount++;
    for (int i = 0; i < 4; i++) begin
      word = ram[13'h0400 + i];
      checkCount++; if (word !== 32'(i + 5)) $display("[TB] FAIL ignore_word%0d: got %h want %h", i, word, 32'(i + 5)); else passCount++;
    end
    word = ram[13'h0500];
    checkCount++; if (word !== 32'hDEADBEEF) $display("[TB] FAIL ignore_untouched: got %h want deadbeef", word); else passCount++;
    checkCount++; if (checksum !== 32'h1A) $display("[TB] FAIL ignore_checksum: got %h want 0000001a", checksum); else passCount++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [DATA_W-1:0] word;
    startCmd(1'b0, 13'h0600, 13'h0900, 14'd8, 32'h0);
    repeat (4) @(negedge clk);
    checkCount++; if (avmIf.avm_chipselect !== 1'b1) $display("[TB] FAIL mid_rd_cs: got %b want 1", avmIf.avm_chipselect); else passCount++;
    #2 reset = 1'b1;
    #1;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL mid_reset_busy: got %b want 0", busy); else passCount++;
    checkCount++; if (avmIf.avm_chipselect !== 1'b0) $display("[TB] FAIL mid_reset_cs: got %b want 0", avmIf.avm_chipselect); else passCount++;
    checkCount++; if (avmIf.avm_address !== 13'h0) $display("[TB] FAIL mid_reset_addr: got %h want 0", avmIf.avm_address); else passCount++;
    checkCount++; if (avmIf.avm_byteenable !== 4'h0) $display("[TB] FAIL mid_reset_be: got %h want 0", avmIf.avm_byteenable); else passCount++;
    checkCount++; if (avmIf.avm_writedata !== 32'h0) $display("[TB] FAIL mid_reset_wdata: got %h want 0", avmIf.avm_writedata); else passCount++;
    checkCount++; if (checksum !== 32'h0) $display("[TB] FAIL mid_reset_checksum: got %h want 0", checksum); else passCount++;
    checkCount++; if (avmIf.avm_clken !== 1'b0) $display("[TB] FAIL mid_reset_clken: got %b want 0", avmIf.avm_clken); else passCount++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL mid_release_busy: got %b want 0", busy); else passCount++;
    startCmd(1'b1, 13'h0, 13'h0300, 14'd1, 32'h0000005A);
    waitDone(cyc);
    checkCount++; if (cyc !== 2) $display("[TB] FAIL mid_fill_latency: got %0d want 2", cyc); else passCount++;
    word = ram[13'h0300];
    checkCount++; if (word !== 32'h5A) $display("[TB] FAIL mid_fill_word: got %h want 0000005a", word); else passCount++;
    checkCount++; if (checksum !== 32'h5A) $display("[TB] FAIL mid_fill_checksum: got %h want 0000005a", checksum); else passCount++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_len0();
    test_ignore_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
